// File: rtl/mbssoc_boot_loader.sv
// Boot loader: frames a byte stream into RAM words, holds the cores
// in reset until the image is loaded, optionally checksum-verified.
// Optional checksum stage: define MBSSOC_BOOT_CSUM_EN.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   rx_valid, rx_data  byte source; rx_ready accepts a byte
//   ram_we/addr/wdata  one-cycle RAM write strobe, address, data
//   cpu_hold_n         0 holds the cores in reset
//   boot_done, err     sticky load-accepted / load-rejected flags
module mbssoc_boot_loader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [ADDR_W-1:0] ADDR_INC = ADDR_W'(1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              cpu_hold_n,
  output logic              boot_done,
  output logic              err
);

  localparam int NB = DATA_W / 8;
  localparam logic [7:0] SYNC = 8'hA5;
  localparam logic [7:0] LAST_B = 8'(NB - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state;
  logic [15:0]       cnt;
  logic [7:0]        bcnt;
  logic [DATA_W-1:0] wbuf;
  logic [DATA_W-1:0] nxt_word;
  logic              take;

  assign take = rx_valid && rx_ready;

  // Little-endian assembly: new byte enters at the top, so after
  // NB bytes the first one received sits in the low byte.
  assign nxt_word = DATA_W'({rx_data, wbuf} >> 8);

`ifdef MBSSOC_BOOT_CSUM_EN
  logic [7:0] csum;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bcnt       <= '0;
      wbuf       <= '0;
      rx_ready   <= 1'b1;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      cpu_hold_n <= 1'b0;
      boot_done  <= 1'b0;
`ifdef MBSSOC_BOOT_CSUM_EN
      csum       <= '0;
      err        <= 1'b0;
`endif
    end else begin
      ram_we <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (take && rx_data == SYNC) begin
            state    <= S_LEN0;
            ram_addr <= BASE_ADDR;
`ifdef MBSSOC_BOOT_CSUM_EN
            csum     <= '0;
`endif
          end
        end
        S_LEN0: begin
          if (take) begin
            cnt[7:0] <= rx_data;
            state    <= S_LEN1;
          end
        end
        S_LEN1: begin
          if (take) begin
            cnt[15:8] <= rx_data;
            bcnt      <= '0;
            if ({rx_data, cnt[7:0]} == 16'd0) begin
`ifdef MBSSOC_BOOT_CSUM_EN
              state      <= S_CSUM;
`else
              state      <= S_DONE;
              rx_ready   <= 1'b0;
              boot_done  <= 1'b1;
              cpu_hold_n <= 1'b1;
`endif
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (take) begin
            wbuf <= nxt_word;
`ifdef MBSSOC_BOOT_CSUM_EN
            csum <= csum ^ rx_data;
`endif
            if (bcnt == LAST_B) begin
              bcnt      <= '0;
              ram_we    <= 1'b1;
              ram_wdata <= nxt_word;
              rx_ready  <= 1'b0;
              state     <= S_WRITE;
            end else begin
              bcnt <= bcnt + 8'd1;
            end
          end
        end
        S_WRITE: begin
          // ram_addr doubles as the address counter; it is bumped
          // only after the strobe cycle has used it.
          ram_addr <= ram_addr + ADDR_INC;
          cnt      <= cnt - 16'd1;
          if (cnt == 16'd1) begin
`ifdef MBSSOC_BOOT_CSUM_EN
            state      <= S_CSUM;
            rx_ready   <= 1'b1;
`else
            state      <= S_DONE;
            boot_done  <= 1'b1;
            cpu_hold_n <= 1'b1;
`endif
          end else begin
            state    <= S_DATA;
            rx_ready <= 1'b1;
          end
        end
`ifdef MBSSOC_BOOT_CSUM_EN
        S_CSUM: begin
          if (take) begin
            rx_ready <= 1'b0;
            if (rx_data == csum) begin
              state      <= S_DONE;
              boot_done  <= 1'b1;
              cpu_hold_n <= 1'b1;
            end else begin
              state <= S_ERR;
              err   <= 1'b1;
            end
          end
        end
`endif
        S_DONE: begin
          state <= S_DONE;
        end
        S_ERR: begin
          state <= S_ERR;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mbssoc_boot_loader.sv
// Bench for mbssoc_boot_loader: two instances (normal base and an
// 8-bit wrapping address space) fed the same byte stream.
module tb_mbssoc_boot_loader;

  localparam logic [31:0] BASE_M = 32'h0000_0100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       rx_valid;
  logic [7:0] rx_data;

  logic        rx_ready, ram_we, cpu_hold_n, boot_done, err;
  logic [31:0] ram_addr, ram_wdata;

  logic        w_rx_ready, w_ram_we, w_cpu_hold_n, w_boot_done, w_err;
  logic [7:0]  w_ram_addr;
  logic [31:0] w_ram_wdata;

  mbssoc_boot_loader #(
    .DATA_W(32), .ADDR_W(32), .BASE_ADDR(BASE_M)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .cpu_hold_n(cpu_hold_n), .boot_done(boot_done), .err(err)
  );

  mbssoc_boot_loader #(
    .DATA_W(32), .ADDR_W(8), .BASE_ADDR(8'hFF)
  ) dut_w (
    .clk(clk), .rst_n(rst_n),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(w_rx_ready),
    .ram_we(w_ram_we), .ram_addr(w_ram_addr),
    .ram_wdata(w_ram_wdata),
    .cpu_hold_n(w_cpu_hold_n), .boot_done(w_boot_done),
    .err(w_err)
  );

  int total = 0;
  int bad = 0;
  int wr_m = 0;
  int wr_w = 0;
  logic [63:0] exp_m[$];
  logic [63:0] exp_w[$];
  logic [31:0] img[$];

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [63:0] e;
    if (rst_n && ram_we) begin
      wr_m++;
      check("we_rdy", {63'd0, rx_ready}, 64'd0);
      if (exp_m.size() == 0) begin
        check("m_extra_we", 64'd1, 64'd0);
      end else begin
        e = exp_m.pop_front();
        check("m_wr", {ram_addr, ram_wdata}, e);
      end
    end
    if (rst_n && w_ram_we) begin
      wr_w++;
      if (exp_w.size() == 0) begin
        check("w_extra_we", 64'd1, 64'd0);
      end else begin
        e = exp_w.pop_front();
        check("w_wr", {24'd0, w_ram_addr, w_ram_wdata}, e);
      end
    end
  end

  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check({tag, "_flags"},
          {59'd0, rx_ready, ram_we, cpu_hold_n, boot_done, err},
          64'h10);
    check({tag, "_addr"}, {32'd0, ram_addr}, 64'd0);
    check({tag, "_wdata"}, {32'd0, ram_wdata}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_m.delete();
    exp_w.delete();
    wr_m = 0;
    wr_w = 0;
  endtask

  task automatic send(input logic [7:0] b, input bit stall);
    int n;
    if (stall) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (!rx_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) check("rdy_timeout", 64'd0, 64'd1);
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  // Sends the image in img; abort>=0 stops after that many payload
  // bytes. flip is XORed into the checksum byte.
  task automatic load(input bit stall, input logic [7:0] flip,
                      input int abort);
    logic [7:0] cs;
    logic [7:0] b;
    logic [15:0] n;
    int sent;
    cs = 8'h00;
    sent = 0;
    n = 16'(img.size());
    send(8'hA5, stall);
    send(n[7:0], stall);
    send(n[15:8], stall);
    for (int i = 0; i < img.size(); i++) begin
      for (int j = 0; j < 4; j++) begin
        if (abort >= 0 && sent == abort) return;
        b = img[i][8*j +: 8];
        cs = cs ^ b;
        if (j == 3) begin
          exp_m.push_back({BASE_M + 32'(i), img[i]});
          exp_w.push_back({24'd0, 8'(8'hFF + i), img[i]});
        end
        send(b, stall);
        sent++;
      end
    end
`ifdef MBSSOC_BOOT_CSUM_EN
    send(cs ^ flip, stall);
`else
    if (flip != 8'h00) check("flip_unused", 64'd1, 64'd0);
    if (n != 16'd0) @(negedge clk);
`endif
  endtask

  task automatic expect_end(input string tag, input bit ok,
                            input int n);
    check({tag, "_done"}, {63'd0, boot_done}, {63'd0, ok});
    check({tag, "_hold"}, {63'd0, cpu_hold_n}, {63'd0, ok});
    check({tag, "_err"}, {63'd0, err}, {63'd0, !ok});
    check({tag, "_rdy"}, {63'd0, rx_ready}, 64'd0);
    check({tag, "_wdone"}, {63'd0, w_boot_done}, {63'd0, ok});
    check({tag, "_werr"}, {63'd0, w_err}, {63'd0, !ok});
    check({tag, "_nwr"}, 64'(wr_m), 64'(n));
    check({tag, "_nwr_w"}, 64'(wr_w), 64'(n));
    check({tag, "_q"}, 64'(exp_m.size() + exp_w.size()), 64'd0);
    repeat (3) @(negedge clk);
    check({tag, "_stay"}, {62'd0, boot_done, cpu_hold_n},
          {62'd0, ok, ok});
  endtask

  initial begin
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    do_reset("rst0");

    send(8'h00, 1'b0);
    send(8'h5A, 1'b0);
    img = '{32'h1234_5678};
    load(1'b0, 8'h00, -1);
    expect_end("sync", 1'b1, 1);

`ifdef MBSSOC_BOOT_CSUM_EN
    do_reset("rst1");
    img = '{32'h1234_5678};
    load(1'b0, 8'h01, -1);
    expect_end("badcs", 1'b0, 1);
`endif

    do_reset("rst2");
    img.delete();
    load(1'b0, 8'h00, -1);
    expect_end("empty", 1'b1, 0);

    do_reset("rst3");
    img = '{32'hDEAD_BEEF, 32'h0102_0304, 32'hCAFE_F00D};
    load(1'b1, 8'h00, -1);
    expect_end("stall", 1'b1, 3);

    do_reset("rst4");
    img = '{32'hA1B2_C3D4, 32'h5566_7788, 32'h99AA_BBCC};
    load(1'b0, 8'h00, 6);
    check("mid_nwr", 64'(wr_m), 64'd1);
    check("mid_done", {63'd0, boot_done}, 64'd0);
    do_reset("midrst");
    load(1'b0, 8'h00, -1);
    expect_end("reload", 1'b1, 3);

    do_reset("rst5");
    img.delete();
    for (int i = 0; i < 6; i++) img.push_back($urandom());
    load(1'b1, 8'h00, -1);
    expect_end("rand", 1'b1, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
